// File: rtl/rpn_pkg.sv
// rpn_pkg: op encodings, FSM states and result width shared by the RPN evaluator.
package rpn_pkg;

    localparam int RES_W = 32;

    typedef enum logic [2:0] {
        OP_PUSH   = 3'd0,
        OP_ADD    = 3'd1,
        OP_SUB    = 3'd2,
        OP_MUL    = 3'd3,
        OP_AND    = 3'd4,
        OP_OR     = 3'd5,
        OP_XOR    = 3'd6,
        OP_RESULT = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP_B  = 3'd1,
        POP_A  = 3'd2,
        CAP_A  = 3'd3,
        PUSH_R = 3'd4,
        POP_R  = 3'd5,
        CAP_R  = 3'd6
    } state_e;

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational A op B for the RPN evaluator.
// RPN_SAT_EN makes ADD/SUB signed-saturating; otherwise they wrap.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = RES_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] sum, dif, prd, add_r, sub_r;

    assign sum = a + b;
    assign dif = a - b;
    assign prd = a * b;

`ifdef RPN_SAT_EN
    localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic add_ov, sub_ov;
    // Overflow only when the result sign disagrees with A under a compatible sign pair.
    assign add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    assign add_r  = add_ov ? (a[WIDTH-1] ? MIN : MAX) : sum;
    assign sub_r  = sub_ov ? (a[WIDTH-1] ? MIN : MAX) : dif;
`else
    assign add_r = sum;
    assign sub_r = dif;
`endif

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = add_r;
            OP_SUB:  y = sub_r;
            OP_MUL:  y = prd;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rpn_eval.sv
// rpn_eval: postfix token evaluator driving an external stack via push/pop.
// ADD/SUB saturation is selected by RPN_SAT_EN inside rpn_alu.
module rpn_eval
    import rpn_pkg::*;
#(
    parameter int WIDTH = RES_W,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       tok_valid,
    output logic                       tok_ready,
    input  logic [2:0]                 tok_op,
    input  logic [WIDTH-1:0]           tok_data,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [WIDTH-1:0]           stk_d,
    input  logic [WIDTH-1:0]           stk_q,
    output logic [WIDTH-1:0]           res,
    output logic                       res_valid,
    output logic                       err,
    input  logic                       err_clr,
    output logic [$clog2(DEPTH+1)-1:0] depth
);

    localparam int DW = $clog2(DEPTH+1);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);
    localparam logic [DW-1:0] TWO  = DW'(2);

    state_e           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, res_q, alu_y;
    logic [2:0]       op_q;
    logic             accept, is_push, is_res, ovf, unf;

    assign tok_ready = state == IDLE;
    assign accept    = tok_valid && tok_ready;
    assign is_push   = tok_op == OP_PUSH;
    assign is_res    = tok_op == OP_RESULT;
    assign ovf       = accept && is_push && depth == FULL;
    assign unf       = accept && (is_res ? depth == '0 : (!is_push && depth < TWO));

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && !unf && !is_push) state_nx = is_res ? POP_R : POP_B;
            POP_B:   state_nx = POP_A;
            POP_A:   state_nx = CAP_A;
            CAP_A:   state_nx = PUSH_R;
            PUSH_R:  state_nx = IDLE;
            POP_R:   state_nx = CAP_R;
            CAP_R:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        stk_push  = (state == PUSH_R) || (accept && is_push && !ovf);
        stk_pop   = state inside {POP_B, POP_A, POP_R};
        stk_d     = state == PUSH_R ? alu_y : (stk_push ? tok_data : '0);
        res_valid = state == CAP_R;
        res       = res_valid ? stk_q : res_q;
    end

    // Operands arrive on stk_q one cycle after each pop edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            depth <= '0;
            err   <= 1'b0;
            res_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            depth <= stk_push ? depth + 1'b1 : (stk_pop ? depth - 1'b1 : depth);
            err   <= err_clr ? 1'b0 : ((ovf || unf) ? 1'b1 : err);
            if (accept)          op_q  <= tok_op;
            if (state == POP_A)  b_q   <= stk_q;
            if (state == CAP_A)  a_q   <= stk_q;
            if (state == CAP_R)  res_q <= stk_q;
        end
    end

endmodule

// File: tb/tb_rpn_eval.sv
// tb_rpn_eval: directed checks of rpn_eval against a behavioural stack.
module tb_rpn_eval;
    import rpn_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic [2:0]  tok_op = 3'd0;
    logic [31:0] tok_data = '0;
    logic        stk_push, stk_pop;
    logic [31:0] stk_d, stk_q, res;
    logic        res_valid, err;
    logic        err_clr = 1'b0;
    logic [4:0]  depth;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    rpn_eval #(.WIDTH(32), .DEPTH(16)) dut (
        .CLK(CLK), .RSTn(RSTn), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_op(tok_op), .tok_data(tok_data), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_d(stk_d), .stk_q(stk_q), .res(res), .res_valid(res_valid),
        .err(err), .err_clr(err_clr), .depth(depth)
    );

    logic [31:0] mem [16];
    int sp;
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sp    <= 0;
            stk_q <= '0;
        end else if (stk_push) begin
            if (sp < 16) mem[sp] <= stk_d;
            sp <= sp + 1;
        end else if (stk_pop) begin
            if (sp > 0 && sp <= 16) stk_q <= mem[sp-1];
            sp <= sp - 1;
        end
    end

    int push_n = 0, pop_n = 0, rv_n = 0, both_n = 0;
    logic [31:0] last_res = '0;
    always @(posedge CLK) begin
        if (stk_push) push_n++;
        if (stk_pop) pop_n++;
        if (stk_push && stk_pop) both_n++;
        if (res_valid) begin
            rv_n++;
            last_res = res;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!tok_ready && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!tok_ready) chk("idle_timeout", 32'(tok_ready), 32'd1);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] d);
        wait_idle();
        tok_valid = 1'b1;
        tok_op    = op;
        tok_data  = d;
        @(posedge CLK);
        #1;
        tok_valid = 1'b0;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
    endtask

    int p0, q0, r0, n;
    logic [31:0] sat_exp;

    initial begin
        #12;
        chk("rst_ready", 32'(tok_ready), 32'd1);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_push_pop_d", {30'd0, stk_push, stk_pop} | stk_d, 32'd0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;

        // 3 + 4
        p0 = push_n; q0 = pop_n; r0 = rv_n;
        send(OP_PUSH, 32'd3);
        send(OP_PUSH, 32'd4);
        send(OP_ADD, 32'd0);
        send(OP_RESULT, 32'd0);
        wait_idle();
        chk("add_pushes", 32'(push_n - p0), 32'd3);
        chk("add_pops", 32'(pop_n - q0), 32'd3);
        chk("add_rv_pulses", 32'(rv_n - r0), 32'd1);
        chk("add_res_pulse", last_res, 32'd7);
        chk("add_res_held", res, 32'd7);
        chk("add_depth", 32'(depth), 32'd0);

        // 10 - 3 and busy length
        send(OP_PUSH, 32'd10);
        send(OP_PUSH, 32'd3);
        send(OP_SUB, 32'd0);
        n = 0;
        while (!tok_ready && n < 20) begin
            n++;
            @(posedge CLK);
            #1;
        end
        chk("sub_busy_cycles", 32'(n), 32'd4);
        chk("sub_depth", 32'(depth), 32'd1);
        send(OP_RESULT, 32'd0);
        wait_idle();
        chk("sub_res", last_res, 32'd7);

        // underflow, err_clr, and err_clr beating a same-cycle set
        send(OP_PUSH, 32'd5);
        q0 = pop_n;
        send(OP_ADD, 32'd0);
        chk("unf_err", 32'(err), 32'd1);
        chk("unf_depth", 32'(depth), 32'd1);
        chk("unf_ready", 32'(tok_ready), 32'd1);
        chk("unf_no_pop", 32'(pop_n - q0), 32'd0);
        err_clr = 1'b1;
        @(posedge CLK);
        #1;
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);
        err_clr = 1'b1;
        send(OP_ADD, 32'd0);
        err_clr = 1'b0;
        chk("clr_wins", 32'(err), 32'd0);
        send(OP_RESULT, 32'd0);
        wait_idle();
        chk("drain_res", last_res, 32'd5);
        chk("drain_depth", 32'(depth), 32'd0);
        send(OP_RESULT, 32'd0);
        chk("result_empty_err", 32'(err), 32'd1);

        // overflow at DEPTH=16
        do_reset();
        p0 = push_n;
        for (int i = 0; i < 17; i++) send(OP_PUSH, 32'(i + 1));
        chk("ovf_pushes", 32'(push_n - p0), 32'd16);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_depth", 32'(depth), 32'd16);
        send(OP_RESULT, 32'd0);
        wait_idle();
        chk("ovf_top", last_res, 32'd16);

        // ADD overflow: saturate or wrap
        do_reset();
`ifdef RPN_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'h8000_0000;
`endif
        send(OP_PUSH, 32'h7FFF_FFFF);
        send(OP_PUSH, 32'd1);
        send(OP_ADD, 32'd0);
        send(OP_RESULT, 32'd0);
        wait_idle();
        chk("add_ovf_res", last_res, sat_exp);

        send(OP_PUSH, 32'd3);
        send(OP_PUSH, 32'd5);
        send(OP_SUB, 32'd0);
        send(OP_RESULT, 32'd0);
        wait_idle();
        chk("sub_neg", last_res, 32'hFFFF_FFFE);

        send(OP_PUSH, 32'h8000_0001);
        send(OP_PUSH, 32'd2);
        send(OP_MUL, 32'd0);
        send(OP_RESULT, 32'd0);
        wait_idle();
        chk("mul_low", last_res, 32'd2);

        send(OP_PUSH, 32'hF0);
        send(OP_PUSH, 32'h3C);
        send(OP_XOR, 32'd0);
        send(OP_PUSH, 32'h0F);
        send(OP_OR, 32'd0);
        send(OP_PUSH, 32'hC3);
        send(OP_AND, 32'd0);
        send(OP_RESULT, 32'd0);
        wait_idle();
        chk("logic_chain", last_res, 32'hC3);

        // reset during POP_A
        do_reset();
        send(OP_RESULT, 32'd0);
        chk("pre_rst_err", 32'(err), 32'd1);
        send(OP_PUSH, 32'd1);
        send(OP_PUSH, 32'd2);
        send(OP_ADD, 32'd0);
        @(posedge CLK);
        #1;
        chk("in_pop_a", 32'(stk_pop), 32'd1);
        RSTn = 1'b0;
        #1;
        chk("mid_rst_pop", 32'(stk_pop), 32'd0);
        chk("mid_rst_depth", 32'(depth), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_ready", 32'(tok_ready), 32'd1);
        chk("post_rst_depth", 32'(depth), 32'd0);
        chk("push_pop_exclusive", 32'(both_n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
